// File: rtl/keystream_server.sv
// Keystream responder: seeded xorshift32 generator feeding a
// hash buffer, serving one byte per request as a single pulse.
package types_pkg;
  typedef enum logic [2:0] {
    H_GROUND      = 3'b000,
    H_FIRST_QUERY = 3'b001,
    H_READY       = 3'b010,
    H_QUERRIED    = 3'b011,
    H_PULSE_OUT   = 3'b100,
    H_EXHAUSTED   = 3'b101
  } hash_generator_state_t;
endpackage

module keystream_server
  import types_pkg::*;
#(
  parameter int BUF_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seed_i,
  input  logic        seed_load_i,
  input  logic        req_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        exhausted_o
);

  localparam int AW = $clog2(BUF_BYTES);
  localparam logic [AW-1:0] LAST = AW'(BUF_BYTES - 1);

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  hash_generator_state_t state_q, state_d;
  logic [31:0]   x_q, x_d, x_nxt;
  logic [AW-1:0] fill_q, fill_d;
  logic [AW-1:0] mark_q, mark_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          exh_q, exh_d;
  logic          buf_we;
  logic [7:0]    buf_q [BUF_BYTES];

  assign x_nxt = xs_step(x_q);

  // Next-state and registered-output decode; seed load overrides all.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    fill_d  = fill_q;
    mark_d  = mark_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    buf_we  = 1'b0;
    if (seed_load_i) begin
      x_d     = (seed_i == 32'h0) ? 32'h1 : seed_i;
      mark_d  = '0;
      state_d = H_GROUND;
    end else begin
      case (state_q)
        H_GROUND: begin
          if (req_i) begin
            state_d = H_FIRST_QUERY;
            fill_d  = '0;
          end
        end
        H_FIRST_QUERY: begin
          x_d    = x_nxt;
          buf_we = 1'b1;
          fill_d = fill_q + AW'(1);
          if (fill_q == LAST) begin
            mark_d  = '0;
            state_d = H_QUERRIED;
          end
        end
        H_READY: begin
          if (req_i) state_d = H_QUERRIED;
        end
        H_QUERRIED: begin
          byte_d  = buf_q[mark_q];
          state_d = H_PULSE_OUT;
        end
        H_PULSE_OUT: begin
          valid_d = 1'b1;
          if (mark_q == LAST) begin
            state_d = H_EXHAUSTED;
          end else begin
            mark_d  = mark_q + AW'(1);
            state_d = H_READY;
          end
        end
        H_EXHAUSTED: begin
          if (req_i) begin
            state_d = H_FIRST_QUERY;
            fill_d  = '0;
          end
        end
        default: state_d = H_GROUND;
      endcase
    end
    busy_d = !((state_d == H_GROUND) ||
               (state_d == H_READY)  ||
               (state_d == H_EXHAUSTED));
    exh_d  = (state_d == H_EXHAUSTED);
  end

  // State, generator, buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= H_GROUND;
      x_q     <= 32'h1;
      fill_q  <= '0;
      mark_q  <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      exh_q   <= 1'b0;
      for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      fill_q  <= fill_d;
      mark_q  <= mark_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      exh_q   <= exh_d;
      if (buf_we) buf_q[fill_q] <= x_nxt[7:0];
    end
  end

  assign byte_o      = byte_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;
  assign exhausted_o = exh_q;

endmodule
